// File: rtl/cr_kme_fifo_prog.sv
// cr_kme_fifo_prog: first-word-fall-through FIFO with programmable stall threshold, flush, sticky errors and high-watermark.
module cr_kme_fifo_prog #(
  parameter int DATA_SIZE   = 132,
  parameter int FIFO_DEPTH  = 16,
  parameter int OVERRIDE_EN = 0,
  parameter int STALL_AT    = 0,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] fifo_in,
  input  logic                 fifo_in_valid,
  output logic                 fifo_in_stall,
  input  logic                 fifo_in_stall_override,
  output logic [DATA_SIZE-1:0] fifo_out,
  output logic                 fifo_out_valid,
  input  logic                 fifo_out_ack,
  input  logic                 thresh_wr,
  input  logic [CW-1:0]        thresh_wdata,
  input  logic                 clear,
  input  logic                 err_clr,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow,
  output logic                 ovf_sticky,
  output logic                 udf_sticky,
  output logic [CW-1:0]        used_slots,
  output logic [CW-1:0]        free_slots,
  output logic [CW-1:0]        high_water
);
  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] used_q, used_d, hw_q, hw_d, thresh_q, thresh_d;
  logic ovf_q, ovf_d, udf_q, udf_d, ovf_st_q, ovf_st_d, udf_st_q, udf_st_d;
  logic full, empty, wen, ren;
  always_comb begin
    full     = used_q == CW'(FIFO_DEPTH);
    empty    = used_q == '0;
    ren      = fifo_out_ack & ~empty & ~clear;
    wen      = fifo_in_valid & (~full | ren) & ~clear;
    ovf_d    = fifo_in_valid & full & ~ren & ~clear;
    udf_d    = fifo_out_ack & empty & ~clear;
    ovf_st_d = (ovf_st_q & ~err_clr) | ovf_d;
    udf_st_d = (udf_st_q & ~err_clr) | udf_d;
    wr_ptr_d = clear ? '0 : ~wen ? wr_ptr_q : wr_ptr_q == AW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + AW'(1);
    rd_ptr_d = clear ? '0 : ~ren ? rd_ptr_q : rd_ptr_q == AW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + AW'(1);
    used_d   = clear ? '0 : (wen & ~ren) ? used_q + CW'(1) : (ren & ~wen) ? used_q - CW'(1) : used_q;
    // Occupancy never exceeds FIFO_DEPTH, so the watermark saturates by construction.
    hw_d     = clear ? '0 : (used_d > hw_q) ? used_d : hw_q;
    thresh_d = thresh_wr ? thresh_wdata : thresh_q;
    fifo_out       = empty ? '0 : mem_q[rd_ptr_q];
    fifo_out_valid = ~empty;
    used_slots     = used_q;
    free_slots     = CW'(FIFO_DEPTH) - used_q;
    high_water     = hw_q;
    fifo_overflow  = ovf_q;
    fifo_underflow = udf_q;
    ovf_sticky     = ovf_st_q;
    udf_sticky     = udf_st_q;
    fifo_in_stall  = (free_slots <= thresh_q) & ~((OVERRIDE_EN != 0) & fifo_in_stall_override);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      hw_q     <= '0;
      thresh_q <= CW'(STALL_AT);
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ovf_st_q <= 1'b0;
      udf_st_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      hw_q     <= hw_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      ovf_st_q <= ovf_st_d;
      udf_st_q <= udf_st_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wen) mem_q[wr_ptr_q] <= fifo_in;
  end
endmodule

// File: doc/cr_kme_fifo_prog.md
Name: cr_kme_fifo_prog

Overview:
- Parametrised first-word-fall-through FIFO for the KME datapath (key/descriptor staging between pipeline stages).
- Successor to the fixed 132-bit, 16-deep KME FIFO. Adds:
  - generic width and depth, including non-power-of-2 depths
  - a runtime-programmable stall threshold
  - synchronous flush
  - sticky error flags with clear
  - occupancy high-watermark for performance debug

Parameters:
- DATA_SIZE, 132, data width in bits.
- FIFO_DEPTH, 16, entries; legal range ≥2; need not be a power of 2.
- OVERRIDE_EN, 0, 1 enables fifo_in_stall_override.
- STALL_AT, 0, reset value of the internal threshold register.
- Derived (not overridable): AW = $clog2(FIFO_DEPTH), CW = $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- fifo_in  in  DATA_SIZE  write data.
- fifo_in_valid  in  1  write request.
- fifo_in_stall  out  1  back-pressure to writer.
- fifo_in_stall_override  in  1  forces stall low when OVERRIDE_EN=1.
- fifo_out  out  DATA_SIZE  head entry; 0 when empty.
- fifo_out_valid  out  1  FIFO non-empty.
- fifo_out_ack  in  1  reader pops head.
- thresh_wr  in  1  load stall threshold.
- thresh_wdata  in  CW  new stall threshold.
- clear  in  1  synchronous flush.
- err_clr  in  1  clears sticky flags.
- fifo_overflow  out  1  single-cycle pulse: write dropped.
- fifo_underflow  out  1  single-cycle pulse: ack while empty.
- ovf_sticky  out  1  latched overflow.
- udf_sticky  out  1  latched underflow.
- used_slots  out  CW  occupancy.
- free_slots  out  CW  FIFO_DEPTH - used_slots.
- high_water  out  CW  maximum used_slots since last rst/clear.

Behaviour:
- Reset (rst=1 at posedge):
  - Pointers, used_slots and high_water go to 0.
  - free_slots = FIFO_DEPTH.
  - thresh register = STALL_AT.
  - All pulses and sticky flags 0.
  - fifo_out_valid = 0, fifo_out = 0.
  - rst has priority over every other input. Reset mid-burst discards all contents.
- Write: wen = fifo_in_valid.
  - Accepted if used_slots < FIFO_DEPTH, or if a read occurs in the same cycle.
  - Data is visible on fifo_out the cycle after acceptance when the FIFO was empty (1-cycle latency).
  - No same-cycle bypass.
- Read: ren = fifo_out_ack & fifo_out_valid.
  - fifo_out is combinational from storage at rd_ptr.
  - fifo_out is forced to 0 when empty.
- Pointers advance by 1 and wrap from FIFO_DEPTH-1 to 0.
- used_slots next state:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous read and write, or on neither.
- Overflow: fifo_in_valid=1, full, no ren, no clear.
  - Write dropped, contents unchanged.
  - fifo_overflow pulses the next cycle; ovf_sticky sets.
- Underflow: fifo_out_ack=1 while empty.
  - No state change.
  - fifo_underflow pulses the next cycle; udf_sticky sets.
- Sticky flags hold until err_clr or rst. If err_clr and a new error occur in the same cycle, the set wins.
- clear:
  - Priority over wen/ren.
  - Empties the FIFO and zeroes high_water.
  - Raises no overflow/underflow in that cycle.
  - Does not alter the thresh register or sticky flags.
- Threshold:
  - thresh_wr loads thresh_wdata on the next edge.
  - Values > FIFO_DEPTH stall permanently; this is legal.
- fifo_in_stall (combinational from registered state):
  - Base term: free_slots ≤ thresh.
  - Forced 0 when OVERRIDE_EN=1 and fifo_in_stall_override=1.
  - With OVERRIDE_EN=0 the override input is ignored.
  - Stall is advisory. A write while stalled but not full is accepted.
- high_water:
  - Updates to used_slots_next when used_slots_next exceeds it.
  - Saturates at FIFO_DEPTH.

Test Plan:
- DEPTH=4, STALL_AT=0: write A,B,C,D back-to-back, no ack -> after 4 cycles used_slots=4, free_slots=0, fifo_in_stall=1, high_water=4. Ack 4 times -> A,B,C,D in order, valid drops after D.
- DEPTH=4 full, write E with no ack -> fifo_overflow pulses 1 cycle, ovf_sticky=1, head still A. Then write F with ack in the same cycle -> A popped, F accepted, used_slots stays 4.
- Empty FIFO, ack asserted -> fifo_underflow pulse, udf_sticky=1, used_slots=0. err_clr -> udf_sticky=0 next cycle.
- DEPTH=5 (non-power-of-2): 12 write/read pairs at occupancy 3 -> data order preserved across pointer wrap; used_slots constant at 3.
- thresh_wr with thresh_wdata=2, DEPTH=4 -> stall asserts at used_slots=2. With OVERRIDE_EN=1 and override=1 -> stall=0. Writes continue to full.
- Occupancy 3, clear together with write and ack -> next cycle used_slots=0, valid=0, high_water=0, no error pulses. rst asserted mid-burst -> all outputs at reset values and thresh=STALL_AT.
